// File: rtl/wb_reg_file.sv
// wb_reg_file: 2**ADDR_W x DATA_W register file with a 2-bit pending-write scoreboard per register.
// Define REGFILE_BYPASS_EN to add write-through bypass from the write-back port to both read ports.
module wb_reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data_reg,
  input  logic [ADDR_W-1:0] read_reg_1,
  input  logic [ADDR_W-1:0] read_reg_2,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_reg,
  output logic              stall,
  output logic              sb_err
);
  localparam int N = 2**ADDR_W;
  logic [DATA_W-1:0] regs_q [N];
  logic [1:0]        cnt_q  [N];
  logic [1:0]        cnt_d  [N];
  logic              sb_err_q, sb_err_d;
  logic              wr_en, iss_en, same, byp_1, byp_2, busy_1, busy_2;
  assign wr_en  = reg_write && write_reg != '0;
  assign iss_en = issue_valid && issue_reg != '0;
  assign same   = wr_en && iss_en && write_reg == issue_reg;
  // an issue and a write-back to the same register cancel, so at most one of inc/dec applies per entry
  always_comb begin
    cnt_d[0] = '0;
    for (int i = 1; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!same && iss_en && issue_reg == ADDR_W'(i) && cnt_q[i] != 2'd3) cnt_d[i] = cnt_q[i] + 2'd1;
      if (!same && wr_en && write_reg == ADDR_W'(i) && cnt_q[i] != 2'd0) cnt_d[i] = cnt_q[i] - 2'd1;
    end
  end
  assign sb_err_d = sb_err_q | (iss_en && !same && cnt_q[issue_reg] == 2'd3);
`ifdef REGFILE_BYPASS_EN
  assign byp_1 = !reset && wr_en && write_reg == read_reg_1;
  assign byp_2 = !reset && wr_en && write_reg == read_reg_2;
`else
  assign byp_1 = 1'b0;
  assign byp_2 = 1'b0;
`endif
  // the last outstanding write retiring this cycle no longer blocks a bypassed port
  assign busy_1 = read_reg_1 != '0 && cnt_q[read_reg_1] != 2'd0 && !(byp_1 && cnt_q[read_reg_1] == 2'd1);
  assign busy_2 = read_reg_2 != '0 && cnt_q[read_reg_2] != 2'd0 && !(byp_2 && cnt_q[read_reg_2] == 2'd1);
  assign stall  = busy_1 | busy_2;
  assign sb_err = sb_err_q;
  assign read_data_1 = read_reg_1 == '0 ? '0 : byp_1 ? write_data_reg : regs_q[read_reg_1];
  assign read_data_2 = read_reg_2 == '0 ? '0 : byp_2 ? write_data_reg : regs_q[read_reg_2];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        regs_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      if (wr_en) regs_q[write_reg] <= write_data_reg;
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
      sb_err_q <= sb_err_d;
    end
  end
endmodule

// File: tb/tb_wb_reg_file.sv
// tb_wb_reg_file: randomized + directed stimulus against an array-based model; a queue-fed monitor checks outputs.
// Honours REGFILE_BYPASS_EN the same way as the design.
module tb_wb_reg_file;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 32;
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          reg_write = 1'b0, issue_valid = 1'b0;
  logic [AW-1:0] write_reg = '0, read_reg_1 = '0, read_reg_2 = '0, issue_reg = '0;
  logic [DW-1:0] write_data_reg = '0;
  logic [DW-1:0] read_data_1, read_data_2;
  logic          stall, sb_err;

  wb_reg_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .reg_write(reg_write), .write_reg(write_reg),
    .write_data_reg(write_data_reg), .read_reg_1(read_reg_1), .read_reg_2(read_reg_2),
    .read_data_1(read_data_1), .read_data_2(read_data_2), .issue_valid(issue_valid),
    .issue_reg(issue_reg), .stall(stall), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] rd1, rd2;
    logic          stl, err;
  } exp_t;
  exp_t exp_q[$];
  int   compared = 0, mismatched = 0;

  int unsigned m_regs [N];
  int          m_cnt  [N];
  bit          m_err;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  function automatic void m_clear();
    for (int i = 0; i < N; i++) begin m_regs[i] = 0; m_cnt[i] = 0; end
    m_err = 0;
  endfunction

  function automatic bit wb_hits(int a);
    return BYP && !reset && reg_write && write_reg != 0 && int'(write_reg) == a;
  endfunction

  function automatic logic [DW-1:0] m_read(int a);
    if (a == 0) return '0;
    if (wb_hits(a)) return write_data_reg;
    return m_regs[a];
  endfunction

  function automatic bit m_blocks(int a);
    if (a == 0 || m_cnt[a] == 0) return 0;
    return !(wb_hits(a) && m_cnt[a] == 1);
  endfunction

  function automatic void m_edge();
    bit wr = reg_write && write_reg != 0;
    bit is = issue_valid && issue_reg != 0;
    if (wr) m_regs[write_reg] = write_data_reg;
    if (wr && is && write_reg == issue_reg) return;
    if (is) begin
      if (m_cnt[issue_reg] == 3) m_err = 1;
      else m_cnt[issue_reg]++;
    end
    if (wr && m_cnt[write_reg] > 0) m_cnt[write_reg]--;
  endfunction

  task automatic step(bit rst, bit wr, int wa, logic [DW-1:0] wd, bit iv, int ir, int r1, int r2);
    exp_t e;
    @(negedge clk);
    reset = rst; reg_write = wr; write_reg = AW'(wa); write_data_reg = wd;
    issue_valid = iv; issue_reg = AW'(ir); read_reg_1 = AW'(r1); read_reg_2 = AW'(r2);
    if (rst) m_clear();
    e.rd1 = m_read(r1);
    e.rd2 = m_read(r2);
    e.stl = m_blocks(r1) || m_blocks(r2);
    e.err = m_err;
    exp_q.push_back(e);
    @(posedge clk);
    if (rst) m_clear(); else m_edge();
  endtask

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("read_data_1", read_data_1, e.rd1);
        chk("read_data_2", read_data_2, e.rd2);
        chk("stall", {31'b0, stall}, {31'b0, e.stl});
        chk("sb_err", {31'b0, sb_err}, {31'b0, e.err});
      end
    end
  end

  initial begin : stim
    int wait_cyc;
    m_clear();
    #1 reset = 1'b1;
    step(1, 1, 5, 32'hFFFF_0000, 1, 5, 5, 5);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    // write/read and r0 behaviour
    step(0, 1, 5, 32'hDEAD_BEEF, 0, 0, 5, 0);
    step(0, 0, 0, 0, 0, 0, 5, 0);
    step(0, 1, 0, 32'h1234, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // issue then write-back r7
    step(0, 0, 0, 0, 1, 7, 0, 7);
    step(0, 0, 0, 0, 0, 0, 0, 7);
    step(0, 1, 7, 32'h55, 0, 0, 0, 7);
    step(0, 0, 0, 0, 0, 0, 0, 7);
    // saturate r3, then drain
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 3, 3, 0);
    step(0, 0, 0, 0, 0, 0, 3, 3);
    for (int i = 0; i < 3; i++) step(0, 1, 3, 32'h300 + i, 0, 0, 3, 0);
    step(0, 0, 0, 0, 0, 0, 3, 0);
    step(0, 1, 3, 32'h399, 0, 0, 3, 0);
    // coincident issue and write-back on r9 with cnt=1
    step(0, 0, 0, 0, 1, 9, 0, 0);
    step(0, 1, 9, 32'h99, 1, 9, 9, 0);
    step(0, 0, 0, 0, 0, 0, 9, 0);
    // mid-sequence async reset with r4 busy
    step(0, 1, 4, 32'h10, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 4, 0, 0);
    step(0, 0, 0, 0, 1, 4, 4, 4);
    step(1, 1, 4, 32'h77, 1, 4, 4, 4);
    step(0, 0, 0, 0, 0, 0, 4, 4);
    // random traffic, small address window for frequent collisions
    for (int i = 0; i < 600; i++) begin
      int hi = ($urandom_range(0, 9) == 0) ? N - 1 : 7;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 1), $urandom_range(0, hi), $urandom,
           $urandom_range(0, 2) == 0, $urandom_range(0, hi), $urandom_range(0, hi), $urandom_range(0, hi));
    end
    @(negedge clk);
    reg_write = 0; issue_valid = 0;
    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 20) begin @(negedge clk); wait_cyc++; end
    #5;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
